// File: rtl/bcd_updown_counter_n.sv
// N-digit packed-BCD up/down counter with validated parallel load, synchronous clear,
// wrap-or-saturate terminal behaviour and a combinational cascade output for chaining.
module bcd_updown_counter_n #(
    parameter int DIGITS = 3,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  enable,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   count,
    output logic                  done,
    output logic                  at_max,
    output logic                  at_min,
    output logic                  load_err
);

    logic [DIGITS-1:0]   dig_max;
    logic [DIGITS-1:0]   dig_min;
    logic [DIGITS-1:0]   dig_bad;
    logic [4*DIGITS-1:0] count_step;
    logic [4*DIGITS-1:0] load_clean;
    logic                carry;
    logic                borrow;
    logic                hold_terminal;

    // Ripple the carry/borrow through a procedural temporary so each digit sees
    // "all lower digits at 9" (up) or "all lower digits at 0" (down).
    always_comb begin
        dig_max    = '0;
        dig_min    = '0;
        dig_bad    = '0;
        count_step = count;
        load_clean = '0;
        carry      = 1'b1;
        borrow     = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            dig_max[k] = (count[4*k +: 4] == 4'd9);
            dig_min[k] = (count[4*k +: 4] == 4'd0);
            dig_bad[k] = (load_val[4*k +: 4] > 4'd9);
            load_clean[4*k +: 4] = dig_bad[k] ? 4'd0 : load_val[4*k +: 4];
            if (up) begin
                if (carry) begin
                    count_step[4*k +: 4] = dig_max[k] ? 4'd0 : count[4*k +: 4] + 4'd1;
                end
            end else begin
                if (borrow) begin
                    count_step[4*k +: 4] = dig_min[k] ? 4'd9 : count[4*k +: 4] - 4'd1;
                end
            end
            carry  = carry  & dig_max[k];
            borrow = borrow & dig_min[k];
        end
    end

    assign at_max = &dig_max;
    assign at_min = &dig_min;
    assign done   = enable & (up ? at_max : at_min);

    // In saturate mode a step toward the terminal value from the terminal is suppressed.
    assign hold_terminal = (WRAP == 1'b0) && done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            load_err <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            load_err <= 1'b0;
        end else if (load) begin
            count    <= load_clean;
            load_err <= |dig_bad;
        end else begin
            load_err <= 1'b0;
            if (enable && !hold_terminal) begin
                count <= count_step;
            end
        end
    end

endmodule
